// File: rtl/cache_mem_backend.sv
// Word-addressed memory backend for cache_wrapper with a fixed request-to-ready latency.
// Optional access counters are enabled by defining CACHE_MEM_BACKEND_STATS_EN.
module cache_mem_backend #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_adr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_ready_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  busy_o,
    output logic [STAT_WIDTH-1:0] rd_count_o,
    output logic [STAT_WIDTH-1:0] wr_count_o
);

    localparam int unsigned IdxW    = $clog2(MEM_DEPTH);
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  req_we;
    logic [IdxW-1:0]       req_idx;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  enter_resp;
    logic                  unused_adr;

    assign unused_adr = ^{mem_adr_i[ADDR_WIDTH-1:IdxW+2], mem_adr_i[1:0]};

    // With LATENCY==1 the array is accessed on the accept edge, before the request regs load.
    always_comb begin
        if (state_q == StIdle) begin
            req_we    = mem_we_i;
            req_idx   = mem_adr_i[IdxW+1:2];
            req_wdata = mem_wdata_i;
        end else begin
            req_we    = we_q;
            req_idx   = idx_q;
            req_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_valid_i) begin
                    we_d    = mem_we_i;
                    idx_d   = mem_adr_i[IdxW+1:2];
                    wdata_d = mem_wdata_i;
                    cnt_d   = CntInit;
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_resp = !rst_i && (state_q != StResp) && (state_d == StResp);

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp && !req_we) begin
            rdata_d = mem_q[req_idx];
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (enter_resp && req_we) begin
            mem_q[req_idx] <= req_wdata;
        end
    end

    always_comb begin
        mem_ready_o = (state_q == StResp);
        busy_o      = (state_q != StIdle);
        mem_rdata_o = rdata_q;
    end

`ifdef CACHE_MEM_BACKEND_STATS_EN
    logic [STAT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [STAT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (enter_resp && !req_we && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (enter_resp && req_we && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`else
    assign rd_count_o = '0;
    assign wr_count_o = '0;
`endif

endmodule
